// File: rtl/calc_seq_unit.sv
// Sequential calculator engine: captures operands on a request, runs one-cycle logic/arith ops
// or WIDTH-step shift-add multiply / restoring divide, and returns a single result pulse.
module calc_seq_unit #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     input_a,
  input  logic [WIDTH-1:0]     input_b,
  input  logic [2:0]           func,
  input  logic                 get_res,
  output logic [2*WIDTH-1:0]   res,
  output logic                 res_valid,
  output logic                 busy,
  output logic                 err
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastIter = CntW'(WIDTH);

  localparam logic [2:0] FnAdd = 3'b000;
  localparam logic [2:0] FnSub = 3'b001;
  localparam logic [2:0] FnMul = 3'b010;
  localparam logic [2:0] FnDiv = 3'b011;
  localparam logic [2:0] FnAnd = 3'b100;
  localparam logic [2:0] FnOr  = 3'b101;

  typedef enum logic [1:0] {StIdle, StExec, StIter, StDone} state_e;

  state_e r_state;
  state_e w_state_next;

  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [2:0]         r_f;
  logic [CntW-1:0]    r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [2*WIDTH-1:0] r_res;
  logic               r_err;

  logic [2*WIDTH-1:0] w_a_ext;
  logic [2*WIDTH-1:0] w_b_ext;
  logic [2*WIDTH-1:0] w_exec_res;
  logic               w_exec_err;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [WIDTH:0]     w_rem_sh;
  logic               w_rem_ge;
  logic [WIDTH-1:0]   w_rem_next;
  logic [WIDTH-1:0]   w_quo_next;
  logic [2*WIDTH-1:0] w_iter_res;
  logic               w_iter_err;
  logic               w_is_iter_fn;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  assign w_is_iter_fn = (func == FnMul) || (func == FnDiv);

  // FSM: next state
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (get_res) begin
          w_state_next = w_is_iter_fn ? StIter : StExec;
        end
      end
      StExec: w_state_next = StDone;
      StIter: begin
        if (r_cnt == LastIter) begin
          w_state_next = StDone;
        end
      end
      StDone: w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy      = 1'b0;
    res_valid = 1'b0;
    unique case (r_state)
      StExec, StIter: busy      = 1'b1;
      StDone:         res_valid = 1'b1;
      default: ;
    endcase
  end

  assign res = r_res;
  assign err = r_err;

  // ---------------------------------------------------------------------------
  // Single-cycle operations
  // ---------------------------------------------------------------------------
  assign w_a_ext = {{WIDTH{1'b0}}, r_a};
  assign w_b_ext = {{WIDTH{1'b0}}, r_b};

  always_comb begin
    w_exec_res = '0;
    w_exec_err = 1'b0;
    case (r_f)
      FnAdd:   w_exec_res = w_a_ext + w_b_ext;
      // Full-width subtraction yields the sign-extended two's complement difference.
      FnSub:   w_exec_res = w_a_ext - w_b_ext;
      FnAnd:   w_exec_res = w_a_ext & w_b_ext;
      FnOr:    w_exec_res = w_a_ext | w_b_ext;
      default: w_exec_err = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Iterative multiply (LSB-first shift-add) and restoring divide (MSB-first)
  // ---------------------------------------------------------------------------
  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  assign w_rem_sh   = {r_rem, r_quo[WIDTH-1]};
  assign w_rem_ge   = (w_rem_sh >= {1'b0, r_b});
  assign w_rem_next = w_rem_ge ? WIDTH'(w_rem_sh - {1'b0, r_b}) : w_rem_sh[WIDTH-1:0];
  assign w_quo_next = {r_quo[WIDTH-2:0], w_rem_ge};

  always_comb begin
    w_iter_res = r_acc;
    w_iter_err = 1'b0;
    if (r_f == FnDiv) begin
      if (r_b == '0) begin
        w_iter_res = {(2*WIDTH){1'b1}};
        w_iter_err = 1'b1;
      end else begin
        w_iter_res = {r_rem, r_quo};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_f      <= '0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_res    <= '0;
      r_err    <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (get_res) begin
            r_a      <= input_a;
            r_b      <= input_b;
            r_f      <= func;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, input_a};
            r_mplier <= input_b;
            r_rem    <= '0;
            r_quo    <= input_a;
          end
        end
        StExec: begin
          r_res <= w_exec_res;
          r_err <= w_exec_err;
        end
        StIter: begin
          if (r_cnt == LastIter) begin
            r_res <= w_iter_res;
            r_err <= w_iter_err;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (r_f == FnMul) begin
              r_acc    <= w_acc_next;
              r_mcand  <= r_mcand << 1;
              r_mplier <= r_mplier >> 1;
            end else begin
              r_rem <= w_rem_next;
              r_quo <= w_quo_next;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_seq_unit.sv
// Scoreboard bench for calc_seq_unit: the driver queues expected results, a monitor checks each
// res_valid pulse for value, error flag, latency and busy duration.
module tb_calc_seq_unit;

  localparam int unsigned W = 4;

  typedef struct {
    logic [2*W-1:0] res;
    logic           err;
    int             lat;
    int             issue;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [W-1:0]   input_a;
  logic [W-1:0]   input_b;
  logic [2:0]     func;
  logic           get_res;
  logic [2*W-1:0] res;
  logic           res_valid;
  logic           busy;
  logic           err;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   busy_run = 0;
  logic prev_valid = 1'b0;
  exp_t sb[$];
  exp_t mon_e;

  calc_seq_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .input_a   (input_a),
    .input_b   (input_b),
    .func      (func),
    .get_res   (get_res),
    .res       (res),
    .res_valid (res_valid),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expected entry per result pulse.
  always @(negedge clk) begin
    if (res_valid === 1'b1) begin
      check("valid_width", {31'b0, prev_valid}, 32'd0);
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_valid: got res=%0h err=%0b, expected no pulse", res, err);
      end else begin
        mon_e = sb.pop_front();
        check("res", {24'b0, res}, {24'b0, mon_e.res});
        check("err", {31'b0, err}, {31'b0, mon_e.err});
        check("latency", cyc - mon_e.issue, mon_e.lat);
        check("busy_len", busy_run, mon_e.lat);
        check("busy_at_valid", {31'b0, busy}, 32'd0);
      end
      busy_run = 0;
    end else if (busy === 1'b1) begin
      busy_run++;
    end else begin
      busy_run = 0;
    end
    prev_valid = (res_valid === 1'b1);
  end

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 30) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: %0d results outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] f,
                    input logic [2*W-1:0] r, input logic e, input int lat);
    exp_t x;
    @(negedge clk);
    input_a = a;
    input_b = b;
    func    = f;
    get_res = 1'b1;
    x.res   = r;
    x.err   = e;
    x.lat   = lat;
    x.issue = cyc + 1;
    sb.push_back(x);
    @(negedge clk);
    // Scramble inputs after capture; the result must not depend on them.
    get_res = 1'b0;
    input_a = ~a;
    input_b = ~b;
    func    = ~f;
    wait_drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t x;
    int   base;
    rst_n   = 1'b0;
    get_res = 1'b0;
    input_a = '0;
    input_b = '0;
    func    = '0;
    repeat (3) @(negedge clk);
    check("rst_res", {24'b0, res}, 32'd0);
    check("rst_valid", {31'b0, res_valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    rst_n = 1'b1;

    op(4'd5, 4'd2, 3'b000, 8'h07, 1'b0, 1);
    op(4'd5, 4'd2, 3'b001, 8'h03, 1'b0, 1);
    op(4'd5, 4'd2, 3'b100, 8'h00, 1'b0, 1);
    op(4'd5, 4'd2, 3'b101, 8'h07, 1'b0, 1);
    op(4'd5, 4'd2, 3'b010, 8'h0A, 1'b0, 5);
    op(4'd15, 4'd15, 3'b010, 8'hE1, 1'b0, 5);
    op(4'd5, 4'd2, 3'b011, 8'h12, 1'b0, 5);
    op(4'd7, 4'd0, 3'b011, 8'hFF, 1'b1, 5);
    op(4'd2, 4'd5, 3'b001, 8'hFD, 1'b0, 1);
    op(4'd5, 4'd2, 3'b111, 8'h00, 1'b1, 1);
    op(4'd15, 4'd15, 3'b110, 8'h00, 1'b1, 1);
    op(4'd15, 4'd15, 3'b000, 8'h1E, 1'b0, 1);
    op(4'd15, 4'd1, 3'b011, 8'h0F, 1'b0, 5);
    op(4'd0, 4'd15, 3'b011, 8'h00, 1'b0, 5);
    op(4'd15, 4'd15, 3'b011, 8'h01, 1'b0, 5);
    op(4'd0, 4'd15, 3'b010, 8'h00, 1'b0, 5);
    op(4'd15, 4'd0, 3'b101, 8'h0F, 1'b0, 1);
    op(4'd0, 4'd15, 3'b001, 8'hF1, 1'b0, 1);

    // get_res held high: one capture every IDLE visit (3-cycle cadence for single-cycle ops).
    @(negedge clk);
    input_a = 4'd5;
    input_b = 4'd2;
    func    = 3'b000;
    get_res = 1'b1;
    base    = cyc;
    for (int i = 0; i < 4; i++) begin
      x.res   = 8'h07;
      x.err   = 1'b0;
      x.lat   = 1;
      x.issue = base + 1 + 3 * i;
      sb.push_back(x);
    end
    repeat (10) @(negedge clk);
    get_res = 1'b0;
    wait_drain();

    // Reset during the third multiply iteration aborts it silently.
    @(negedge clk);
    input_a = 4'd5;
    input_b = 4'd2;
    func    = 3'b010;
    get_res = 1'b1;
    @(negedge clk);
    get_res = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_res", {24'b0, res}, 32'd0);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_valid", {31'b0, res_valid}, 32'd0);
    check("abort_err", {31'b0, err}, 32'd0);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    op(4'd5, 4'd3, 3'b010, 8'h0F, 1'b0, 5);

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
